// File: rtl/cpu_pkg.sv
// Shared datapath constants for the 8-bit single-cycle processor:
// ALU function codes and datapath widths.
package cpu_pkg;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011
  } alu_op_e;
endpackage

// File: rtl/alu_regfile_if.sv
// Control/data bundle between the decoder side and the register-file + ALU core.
interface alu_regfile_if;
  import cpu_pkg::*;

  logic [REG_ADDR_W-1:0] WRITEREG;
  logic [REG_ADDR_W-1:0] READREG1;
  logic [REG_ADDR_W-1:0] READREG2;
  logic                  WRITEENABLE;
  logic [2:0]            ALUOP;
  logic [DATA_W-1:0]     OPERAND2;
  logic [DATA_W-1:0]     REGOUT1;
  logic [DATA_W-1:0]     REGOUT2;
  logic [DATA_W-1:0]     ALUOUT;

  modport master (
    output WRITEREG, READREG1, READREG2, WRITEENABLE, ALUOP, OPERAND2,
    input  REGOUT1, REGOUT2, ALUOUT
  );

  modport slave (
    input  WRITEREG, READREG1, READREG2, WRITEENABLE, ALUOP, OPERAND2,
    output REGOUT1, REGOUT2, ALUOUT
  );
endinterface

// File: rtl/alu8.sv
// Combinational 8-bit ALU: forward, add (carry dropped), and, or; reserved codes give 0.
module alu8
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [2:0]        select_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (select_i)
      ALU_FWD: result_o = data2_i;
      ALU_ADD: result_o = data1_i + data2_i;
      ALU_AND: result_o = data1_i & data2_i;
      ALU_OR:  result_o = data1_i | data2_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_regfile.sv
// 8x8 register file (two combinational reads, one clocked write) fused with alu8;
// the ALU result is the write data.
module alu_regfile
  import cpu_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  alu_regfile_if.slave  bus
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               alu_res;

  // Reads see only committed state; no bypass of the in-flight write.
  assign bus.REGOUT1 = regs_q[bus.READREG1];
  assign bus.REGOUT2 = regs_q[bus.READREG2];
  assign bus.ALUOUT  = alu_res;

  alu8 u_alu (
    .data1_i  (regs_q[bus.READREG1]),
    .data2_i  (bus.OPERAND2),
    .select_i (bus.ALUOP),
    .result_o (alu_res)
  );

  always_comb begin
    regs_d = regs_q;
    if (bus.WRITEENABLE) regs_d[bus.WRITEREG] = alu_res;
  end

  // Reset wins over a same-edge write.
  always_ff @(posedge CLK) begin
    if (!RESET) regs_q <= '0;
    else        regs_q <= regs_d;
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Self-checking bench for alu_regfile: directed scenarios plus random traffic
// against an array-based model of the register file and ALU rules.
module tb_alu_regfile;
  import cpu_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  alu_regfile_if bus();

  alu_regfile dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  logic [7:0] model [8];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] alu_ref(logic [7:0] a, logic [7:0] b, logic [2:0] op);
    int s;
    case (op)
      3'd0: return b;
      3'd1: begin s = int'(a) + int'(b); return 8'(s % 256); end
      3'd2: return a & b;
      3'd3: return a | b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive(bit rst, bit we, logic [2:0] wr, logic [2:0] r1, logic [2:0] r2,
                       logic [2:0] op, logic [7:0] o2);
    RESET = rst; bus.WRITEENABLE = we; bus.WRITEREG = wr;
    bus.READREG1 = r1; bus.READREG2 = r2; bus.ALUOP = op; bus.OPERAND2 = o2;
    #1;
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic step();
    logic [7:0] wd;
    wd = alu_ref(model[bus.READREG1], bus.OPERAND2, bus.ALUOP);
    @(posedge CLK);
    if (!RESET) for (int i = 0; i < 8; i++) model[i] = 8'h00;
    else if (bus.WRITEENABLE) model[bus.WRITEREG] = wd;
    #1;
  endtask

  task automatic load(logic [2:0] r, logic [7:0] v);
    drive(1, 1, r, 0, 0, 3'd0, v);
    step();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) load(3'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 3'(i), 3'(7 - i), 3'd0, 8'h00);
      n_cmp++;
      if (bus.REGOUT1 !== 8'(8'h11 * (i + 1))) begin
        n_err++; $display("FAIL preload r%0d: got %h want %h", i, bus.REGOUT1, 8'(8'h11 * (i + 1)));
      end
    end
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 3'(i), 3'(i), 3'd1, 8'h5A);
      n_cmp++;
      if (bus.REGOUT1 !== 8'h00 || bus.REGOUT2 !== 8'h00 || bus.ALUOUT !== 8'h5A) begin
        n_err++;
        $display("FAIL reset_read r%0d: got %h/%h alu %h want 00/00 alu 5a",
                 i, bus.REGOUT1, bus.REGOUT2, bus.ALUOUT);
      end
    end
  endtask

  task automatic test_loadi();
    load(3'd4, 8'h05);
    drive(1, 0, 0, 3'd4, 3'd0, 3'd0, 8'h00);
    n_cmp++;
    if (bus.REGOUT1 !== 8'h05) begin n_err++; $display("FAIL loadi_r4: got %h want 05", bus.REGOUT1); end
    load(3'd2, 8'h09);
    drive(1, 0, 0, 3'd2, 3'd4, 3'd0, 8'h00);
    n_cmp++;
    if (bus.REGOUT1 !== 8'h09 || bus.REGOUT2 !== 8'h05) begin
      n_err++; $display("FAIL loadi_r2: got %h/%h want 09/05", bus.REGOUT1, bus.REGOUT2);
    end
  endtask

  task automatic test_add_sub();
    load(3'd4, 8'h05);
    drive(1, 1, 3'd6, 3'd4, 3'd0, 3'd1, 8'h09);
    n_cmp++;
    if (bus.ALUOUT !== 8'h0E) begin n_err++; $display("FAIL add: got %h want 0e", bus.ALUOUT); end
    step();
    drive(1, 0, 0, 3'd6, 3'd0, 3'd1, 8'hF7);
    n_cmp++;
    if (bus.REGOUT1 !== 8'h0E) begin n_err++; $display("FAIL add_wr_r6: got %h want 0e", bus.REGOUT1); end
    drive(1, 0, 0, 3'd4, 3'd0, 3'd1, 8'hF7);
    n_cmp++;
    if (bus.ALUOUT !== 8'hFC) begin n_err++; $display("FAIL sub: got %h want fc", bus.ALUOUT); end
    load(3'd7, 8'hFF);
    drive(1, 0, 0, 3'd7, 3'd0, 3'd1, 8'h01);
    n_cmp++;
    if (bus.ALUOUT !== 8'h00) begin n_err++; $display("FAIL add_wrap: got %h want 00", bus.ALUOUT); end
    // Read-modify-write of the same register uses the pre-edge value once.
    load(3'd2, 8'h10);
    drive(1, 1, 3'd2, 3'd2, 3'd2, 3'd1, 8'h07);
    step();
    step();
    drive(1, 0, 0, 3'd2, 3'd2, 3'd0, 8'h00);
    n_cmp++;
    if (bus.REGOUT1 !== model[2] || model[2] !== 8'h1E) begin
      n_err++; $display("FAIL rmw_r2: got %h want 1e", bus.REGOUT1);
    end
  endtask

  task automatic test_logic();
    load(3'd1, 8'h0C);
    drive(1, 0, 0, 3'd1, 0, 3'd2, 8'h0A);
    n_cmp++;
    if (bus.ALUOUT !== 8'h08) begin n_err++; $display("FAIL and: got %h want 08", bus.ALUOUT); end
    drive(1, 0, 0, 3'd1, 0, 3'd3, 8'h0A);
    n_cmp++;
    if (bus.ALUOUT !== 8'h0E) begin n_err++; $display("FAIL or: got %h want 0e", bus.ALUOUT); end
    for (int op = 4; op < 8; op++) begin
      drive(1, 0, 0, 3'd1, 0, 3'(op), 8'h0A);
      n_cmp++;
      if (bus.ALUOUT !== 8'h00) begin n_err++; $display("FAIL reserved_op%0d: got %h want 00", op, bus.ALUOUT); end
    end
  endtask

  task automatic test_write_enable();
    load(3'd5, 8'h3C);
    drive(1, 0, 3'd5, 3'd5, 3'd5, 3'd0, 8'hAA);
    step();
    n_cmp++;
    if (bus.REGOUT1 !== 8'h3C) begin n_err++; $display("FAIL we0_hold: got %h want 3c", bus.REGOUT1); end
    drive(1, 1, 3'd5, 3'd5, 3'd5, 3'd0, 8'hAA);
    n_cmp++;
    if (bus.REGOUT1 !== 8'h3C || bus.REGOUT2 !== 8'h3C) begin
      n_err++; $display("FAIL no_bypass: got %h/%h want 3c/3c", bus.REGOUT1, bus.REGOUT2);
    end
    step();
    n_cmp++;
    if (bus.REGOUT1 !== 8'hAA || bus.REGOUT2 !== 8'hAA) begin
      n_err++; $display("FAIL post_write: got %h/%h want aa/aa", bus.REGOUT1, bus.REGOUT2);
    end
  endtask

  task automatic test_reset_vs_write();
    load(3'd3, 8'h77);
    drive(0, 1, 3'd3, 3'd3, 3'd3, 3'd0, 8'h33);
    step();
    n_cmp++;
    if (bus.REGOUT1 !== 8'h00) begin n_err++; $display("FAIL rst_priority: got %h want 00", bus.REGOUT1); end
    // Several reset edges with write enable high keep everything at zero.
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 3'd3, 3'(i), 3'(i), 3'd0, 8'h33);
      n_cmp++;
      if (bus.REGOUT1 !== 8'h00) begin n_err++; $display("FAIL rst_hold r%0d: got %h want 00", i, bus.REGOUT1); end
    end
    drive(1, 1, 3'd3, 3'd3, 3'd3, 3'd0, 8'h33);
    step();
    n_cmp++;
    if (bus.REGOUT1 !== 8'h33) begin n_err++; $display("FAIL write_after_rst: got %h want 33", bus.REGOUT1); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 19) != 0), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            8'($urandom_range(0, 255)));
      n_cmp++;
      if (bus.REGOUT1 !== model[bus.READREG1] || bus.REGOUT2 !== model[bus.READREG2] ||
          bus.ALUOUT !== alu_ref(model[bus.READREG1], bus.OPERAND2, bus.ALUOP)) begin
        n_err++;
        $display("FAIL rand%0d: got %h/%h alu %h want %h/%h alu %h", n, bus.REGOUT1, bus.REGOUT2,
                 bus.ALUOUT, model[bus.READREG1], model[bus.READREG2],
                 alu_ref(model[bus.READREG1], bus.OPERAND2, bus.ALUOP));
      end
      step();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 3'd0, 8'h00);
    @(negedge CLK);
    test_reset();
    test_loadi();
    test_add_sub();
    test_logic();
    test_write_enable();
    test_reset_vs_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
